// File: rtl/fp_operand_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fp_operand_loader                                             |
// | Purpose  : Push-button/slide-switch operand entry for the FPALU demo.    |
// |            Keys and switches pass through a 2-FF synchronizer. Presses   |
// |            on key 0/1 write a 10-bit chunk into the A/B staging word.    |
// |            The fourth chunk commits the whole word atomically.           |
// |            Key 2 cancels entry. Key 3 clears the operands.               |
// | Config   : define OPLOAD_DEBOUNCE_EN to enable the key debouncer. When   |
// |            it is undefined, a synchronized 1->0 edge is a press.         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fp_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        iclock,
  input  logic        ireset_n,
  input  logic [3:0]  ikey,
  input  logic [9:0]  isw,
  output logic [31:0] odataa,
  output logic [31:0] odatab,
  output logic [1:0]  ochunk_a,
  output logic [1:0]  ochunk_b,
  output logic        oload_a,
  output logic        oload_b
);

  localparam logic [3:0] c_keys_released = 4'hF;

  logic [3:0]  r_key_s1;
  logic [3:0]  r_key_s2;
  logic [9:0]  r_sw_s1;
  logic [9:0]  r_sw_s2;
  logic [3:0]  r_key_db;   // debounced key level, 1 = released
  logic [3:0]  r_press;    // one-cycle press events, one bit per key

  logic [31:0] r_stage_a;
  logic [31:0] r_stage_b;
  logic [31:0] w_stage_a_next;
  logic [31:0] w_stage_b_next;

  // Places one switch chunk into a staging word; chunk 3 holds only the two LSBs.
  function automatic logic [31:0] f_insert(input logic [31:0] word,
                                           input logic [1:0]  idx,
                                           input logic [9:0]  sw);
    logic [31:0] res;
    case (idx)
      2'd0:    res = {sw, word[21:0]};
      2'd1:    res = {word[31:22], sw, word[11:0]};
      2'd2:    res = {word[31:12], sw, word[1:0]};
      default: res = {word[31:2], sw[1:0]};
    endcase
    return res;
  endfunction

  // Two-flop synchronizer for the asynchronous keys and switches.
  always_ff @(posedge iclock) begin
    if (!ireset_n) begin
      r_key_s1 <= c_keys_released;
      r_key_s2 <= c_keys_released;
      r_sw_s1  <= '0;
      r_sw_s2  <= '0;
    end else begin
      r_key_s1 <= ikey;
      r_key_s2 <= r_key_s1;
      r_sw_s1  <= isw;
      r_sw_s2  <= r_sw_s1;
    end
  end

`ifdef OPLOAD_DEBOUNCE_EN
  localparam logic [19:0] c_cnt_last = 20'(DEBOUNCE_CYCLES - 1);

  logic [19:0] r_cnt [4];

  // Per-key debouncer: a level must differ from the debounced state for
  // DEBOUNCE_CYCLES consecutive samples before it is accepted; only the
  // released->pressed flip raises a press event.
  always_ff @(posedge iclock) begin
    if (!ireset_n) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
      r_key_db <= c_keys_released;
      r_press  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        r_press[k] <= 1'b0;
        if (r_key_s2[k] == r_key_db[k]) begin
          r_cnt[k] <= '0;
        end else if (r_cnt[k] == c_cnt_last) begin
          r_cnt[k]    <= '0;
          r_key_db[k] <= r_key_s2[k];
          r_press[k]  <= r_key_db[k];
        end else begin
          r_cnt[k] <= r_cnt[k] + 20'd1;
        end
      end
    end
  end
`else
  logic w_unused_cfg;
  assign w_unused_cfg = |DEBOUNCE_CYCLES;

  // No filtering: any synchronized released->pressed edge is a press event.
  always_ff @(posedge iclock) begin
    if (!ireset_n) begin
      r_key_db <= c_keys_released;
      r_press  <= '0;
    end else begin
      r_key_db <= r_key_s2;
      r_press  <= r_key_db & ~r_key_s2;
    end
  end
`endif

  // Staging words as they would look after writing the current chunk.
  always_comb begin
    w_stage_a_next = f_insert(r_stage_a, ochunk_a, r_sw_s2);
    w_stage_b_next = f_insert(r_stage_b, ochunk_b, r_sw_s2);
  end

  // Operand assembly; clear beats cancel, and both beat chunk entry.
  always_ff @(posedge iclock) begin
    if (!ireset_n) begin
      r_stage_a <= '0;
      r_stage_b <= '0;
      odataa    <= '0;
      odatab    <= '0;
      ochunk_a  <= '0;
      ochunk_b  <= '0;
      oload_a   <= 1'b0;
      oload_b   <= 1'b0;
    end else begin
      oload_a <= 1'b0;
      oload_b <= 1'b0;
      if (r_press[3]) begin
        r_stage_a <= '0;
        r_stage_b <= '0;
        odataa    <= '0;
        odatab    <= '0;
        ochunk_a  <= '0;
        ochunk_b  <= '0;
      end else if (r_press[2]) begin
        r_stage_a <= '0;
        r_stage_b <= '0;
        ochunk_a  <= '0;
        ochunk_b  <= '0;
      end else begin
        if (r_press[0]) begin
          r_stage_a <= w_stage_a_next;
          ochunk_a  <= ochunk_a + 2'd1;
          if (ochunk_a == 2'd3) begin
            odataa  <= w_stage_a_next;
            oload_a <= 1'b1;
          end
        end
        if (r_press[1]) begin
          r_stage_b <= w_stage_b_next;
          ochunk_b  <= ochunk_b + 2'd1;
          if (ochunk_b == 2'd3) begin
            odatab  <= w_stage_b_next;
            oload_b <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_operand_loader.md
# fp_operand_loader

Operand-entry front end for the FPALU board demo. It debounces the four push-buttons and assembles full 32-bit single-precision operands A and B from the 10 slide switches across four chunk entries per operand. Completed operands are presented atomically to the FPALU datapath, so the ALU can be driven with arbitrary IEEE-754 values instead of only the upper 10 bits.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: stable-level cycles required to accept a key edge (10 ms at 50 MHz); legal range 2..2^20−1.
- `iclock`  in  1: system clock (50 MHz on board).
- `ireset_n`  in  1: reset, **one clock; reset is synchronous and active-low**.
- `ikey`  in  4: raw push-buttons, active-low, asynchronous. [0]=enter chunk A, [1]=enter chunk B, [2]=cancel entry, [3]=clear operands.
- `isw`  in  10: raw slide switches, sampled through the same 2-FF synchronizer as `ikey`.
- `odataa`  out  32: committed operand A.
- `odatab`  out  32: committed operand B.
- `ochunk_a`  out  2: index of the next chunk expected for A.
- `ochunk_b`  out  2: index of the next chunk expected for B.
- `oload_a`  out  1: one-cycle pulse when A commits.
- `oload_b`  out  1: one-cycle pulse when B commits.

## Operation
- Reset (`ireset_n`=0 at a rising edge): all outputs 0; both staging registers 0; chunk indices 0; synchronizers and debounced key states = released (1); debounce counters 0.
- Synchronizer: `ikey` and `isw` pass through 2 flops. Debounced switch value = synchronized value; no filtering.
- Debouncer, per key: counter runs while the synchronized level differs from the debounced state and clears when they match. When the count reaches DEBOUNCE_CYCLES−1, the debounced state flips. A flip 1→0 produces one press event (1 cycle). Releases produce no event.
- Chunk map, per operand, index k:
  - k=0 → bits[31:22] = isw[9:0]
  - k=1 → bits[21:12] = isw[9:0]
  - k=2 → bits[11:2] = isw[9:0]
  - k=3 → bits[1:0] = isw[1:0]; isw[9:2] ignored.
- Press on key 0 (or key 1) writes chunk k of the A (or B) staging register and increments k.
- At k=3, the write also loads `odataa` (or `odatab`) with the full staged word, pulses `oload_a` (or `oload_b`), and wraps k to 0. The staging register retains its value.
- Cancel (key 2): both indices → 0, both staging registers → 0. Committed outputs are unchanged.
- Clear (key 3): `odataa`, `odatab`, both staging registers, and both indices → 0. No load pulse.
- Simultaneous events in one cycle:
  - A and B entries proceed independently.
  - Cancel or clear overrides any entry press in the same cycle.
  - Clear overrides cancel.

## Timing
- Raw key falls before edge t and stays low. The synchronized level is low at t+2. The press event fires at t+2+DEBOUNCE_CYCLES−1. Register updates (staging, index, `odata*`, `oload_*`) are visible at t+2+DEBOUNCE_CYCLES.
- The switch value written is the synchronized `isw` in the event cycle.
- Glitches shorter than DEBOUNCE_CYCLES produce no event and reset the counter.
- Minimum spacing between accepted presses of one key: 2×DEBOUNCE_CYCLES (press plus release).
- `oload_*` is high for exactly 1 cycle. `odata*` is stable at all other times.
- Reset asserted mid-entry discards partial chunks. A key held through reset release yields one press after debounce.

## Configuration
- `OPLOAD_DEBOUNCE_EN` defined: debouncer as specified.
- Not defined: debouncer removed. The event fires on the first cycle the synchronized key is 0 after being 1, and updates are visible at t+3. DEBOUNCE_CYCLES is ignored. Use for fast simulation or for external clean key sources.

## Test plan
- Reset, DEBOUNCE_CYCLES=4, macro defined: hold `ireset_n`=0 for 2 cycles → all outputs 0, `ochunk_a`=`ochunk_b`=0.
- A entry: 4 presses of key 0 with isw=0x0FE, 0x000, 0x000, 0x000 → `odataa`=0x3F800000 (1.0); `oload_a` is a single pulse in the 4th update cycle; `ochunk_a` steps 1,2,3,0.
- Bounce: key 0 low for 3 cycles, high 1 cycle, then low 6 cycles → exactly one event; `ochunk_a`=1 only after a continuous 4-cycle low.
- Simultaneous: key 1 press and key 2 press debounce in the same cycle with `ochunk_b`=2 → `ochunk_b`=0, B staging 0, `odatab` unchanged, no `oload_b`.
- Clear: after committing A=0x40000000, press key 3 → `odataa`=0, `odatab`=0, indices 0.
- Macro undefined: one key 0 press → `ochunk_a`=1 exactly 3 cycles after the raw edge; reset mid-entry at `ochunk_a`=2 → `ochunk_a`=0 and `odataa` unchanged from 0.
